// File: rtl/reg_rename_map.sv
// Register rename stage: speculative and retirement architectural->physical maps,
// free-list bitmap allocation, commit-time recycling and single-cycle flush recovery.
module reg_rename_map #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_uses_rs,
    input  logic       i_uses_rt,
    input  logic       i_uses_rw,
    input  logic [4:0] i_rs_addr,
    input  logic [4:0] i_rt_addr,
    input  logic [4:0] i_rw_addr,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_uses_rs,
    output logic       o_uses_rt,
    output logic       o_uses_rw,
    output logic [5:0] o_rs_phys,
    output logic [5:0] o_rt_phys,
    output logic [5:0] o_rw_phys,
    output logic [5:0] o_old_rw_phys,
    input  logic       commit_valid,
    input  logic       commit_uses_rw,
    input  logic [4:0] commit_rw_addr,
    input  logic [5:0] commit_rw_phys,
    input  logic [5:0] commit_old_phys,
    input  logic       flush,
    output logic [6:0] o_free_count
);

    localparam int PW = 6;
    localparam int CW = 7;
    localparam logic [PHYS_REGS-1:0] FREE_RST =
        {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

    // Handshake: a transfer happens on any edge where valid && ready are both high;
    // the producer holds its payload stable while valid && !ready.
    logic [ARCH_REGS-1:0][PW-1:0] spec_map;
    logic [ARCH_REGS-1:0][PW-1:0] ret_map;
    logic [ARCH_REGS-1:0][PW-1:0] ret_next;
    logic [PHYS_REGS-1:0]         free_q;
    logic [PHYS_REGS-1:0]         free_d;
    logic [PHYS_REGS-1:0]         live;
    logic [PW-1:0]                alloc_tag;
    logic [CW-1:0]                free_cnt_d;
    logic                         have_free;
    logic                         need_alloc;
    logic                         accept;
    logic                         commit_fire;

    assign need_alloc  = i_uses_rw && (i_rw_addr != 5'd0);
    assign have_free   = |free_q;
    assign o_ready     = !flush && (!o_valid || i_ready) && (!need_alloc || have_free);
    assign accept      = i_valid && o_ready;
    assign commit_fire = commit_valid && commit_uses_rw && (commit_rw_addr != 5'd0);

    // Lowest-indexed free tag wins.
    always_comb begin
        alloc_tag = '0;
        for (int i = PHYS_REGS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag = PW'(i);
        end
    end

    always_comb begin
        ret_next = ret_map;
        if (commit_fire) ret_next[commit_rw_addr] = commit_rw_phys;
    end

    // Tags still referenced by the retirement map after this cycle's commit.
    always_comb begin
        live = '0;
        for (int i = 0; i < ARCH_REGS; i++) live[ret_next[i]] = 1'b1;
    end

    always_comb begin
        free_d = free_q;
        if (commit_fire) free_d[commit_old_phys] = 1'b1;
        if (flush) begin
            free_d = ~live;
        end else if (accept && need_alloc) begin
            free_d[alloc_tag] = 1'b0;
        end
        free_d[0] = 1'b0;
    end

    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < PHYS_REGS; i++) free_cnt_d = free_cnt_d + CW'(free_d[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i] <= PW'(i);
                ret_map[i]  <= PW'(i);
            end
            free_q        <= FREE_RST;
            o_free_count  <= CW'(PHYS_REGS - ARCH_REGS);
            o_valid       <= 1'b0;
            o_uses_rs     <= 1'b0;
            o_uses_rt     <= 1'b0;
            o_uses_rw     <= 1'b0;
            o_rs_phys     <= '0;
            o_rt_phys     <= '0;
            o_rw_phys     <= '0;
            o_old_rw_phys <= '0;
        end else begin
            free_q       <= free_d;
            o_free_count <= free_cnt_d;
            ret_map      <= ret_next;
            if (flush) begin
                spec_map <= ret_next;
                o_valid  <= 1'b0;
            end else if (accept) begin
                o_valid   <= 1'b1;
                o_uses_rs <= i_uses_rs;
                o_uses_rt <= i_uses_rt;
                o_rs_phys <= i_uses_rs ? spec_map[i_rs_addr] : '0;
                o_rt_phys <= i_uses_rt ? spec_map[i_rt_addr] : '0;
                // Sources above sample the map before this destination update lands.
                if (need_alloc) begin
                    o_uses_rw           <= 1'b1;
                    o_rw_phys           <= alloc_tag;
                    o_old_rw_phys       <= spec_map[i_rw_addr];
                    spec_map[i_rw_addr] <= alloc_tag;
                end else begin
                    o_uses_rw     <= 1'b0;
                    o_rw_phys     <= '0;
                    o_old_rw_phys <= '0;
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    // Commit must release a tag that is currently allocated and distinct from its new one.
    always_ff @(posedge clk) begin
        if (commit_fire) begin
            assert (commit_old_phys == '0 || !free_q[commit_old_phys]);
            assert (commit_old_phys != commit_rw_phys);
        end
    end

endmodule

// File: tb/tb_reg_rename_map.sv
// Directed bench for reg_rename_map: rename, allocation exhaustion, recycle,
// r0 handling, flush recovery (with and without same-cycle commit), stall and async reset.
module tb_reg_rename_map;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid, o_ready;
    logic       i_uses_rs, i_uses_rt, i_uses_rw;
    logic [4:0] i_rs_addr, i_rt_addr, i_rw_addr;
    logic       o_valid, i_ready;
    logic       o_uses_rs, o_uses_rt, o_uses_rw;
    logic [5:0] o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys;
    logic       commit_valid, commit_uses_rw;
    logic [4:0] commit_rw_addr;
    logic [5:0] commit_rw_phys, commit_old_phys;
    logic       flush;
    logic [6:0] o_free_count;

    int errors = 0;
    int checks = 0;

    reg_rename_map dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt), .i_uses_rw(i_uses_rw),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rw_addr(i_rw_addr),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_uses_rs(o_uses_rs), .o_uses_rt(o_uses_rt), .o_uses_rw(o_uses_rw),
        .o_rs_phys(o_rs_phys), .o_rt_phys(o_rt_phys), .o_rw_phys(o_rw_phys),
        .o_old_rw_phys(o_old_rw_phys),
        .commit_valid(commit_valid), .commit_uses_rw(commit_uses_rw),
        .commit_rw_addr(commit_rw_addr), .commit_rw_phys(commit_rw_phys),
        .commit_old_phys(commit_old_phys),
        .flush(flush), .o_free_count(o_free_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        i_valid = 1'b0; i_uses_rs = 1'b0; i_uses_rt = 1'b0; i_uses_rw = 1'b0;
        i_rs_addr = '0; i_rt_addr = '0; i_rw_addr = '0;
    endtask

    task automatic clear_commit();
        commit_valid = 1'b0; commit_uses_rw = 1'b0; commit_rw_addr = '0;
        commit_rw_phys = '0; commit_old_phys = '0;
    endtask

    task automatic set_in(input logic urs, input logic [4:0] rs, input logic urt,
                          input logic [4:0] rt, input logic urw, input logic [4:0] rw);
        i_valid = 1'b1;
        i_uses_rs = urs; i_rs_addr = rs;
        i_uses_rt = urt; i_rt_addr = rt;
        i_uses_rw = urw; i_rw_addr = rw;
    endtask

    task automatic ren(input logic urs, input logic [4:0] rs, input logic urt,
                       input logic [4:0] rt, input logic urw, input logic [4:0] rw);
        set_in(urs, rs, urt, rt, urw, rw);
        tick();
        clear_in();
    endtask

    task automatic set_commit(input logic [4:0] addr, input logic [5:0] phys,
                              input logic [5:0] old);
        commit_valid = 1'b1; commit_uses_rw = 1'b1;
        commit_rw_addr = addr; commit_rw_phys = phys; commit_old_phys = old;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [4:0] rw;
        rst = 1'b1; i_ready = 1'b1; flush = 1'b0;
        clear_in();
        clear_commit();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state.
        chk("reset_o_valid", o_valid, 0);
        chk("reset_free_count", o_free_count, 32);
        chk("reset_o_ready", o_ready, 1);
        chk("reset_rw_phys", o_rw_phys, 0);

        // Sources only, no destination.
        ren(1, 3, 1, 4, 0, 0);
        chk("src_valid", o_valid, 1);
        chk("src_rs", o_rs_phys, 3);
        chk("src_rt", o_rt_phys, 4);
        chk("src_uses_rw", o_uses_rw, 0);
        chk("src_rw_phys", o_rw_phys, 0);

        // r5 <- r5, r6: sources see the pre-update mapping.
        ren(1, 5, 1, 6, 1, 5);
        chk("r5_rw_phys", o_rw_phys, 32);
        chk("r5_old", o_old_rw_phys, 5);
        chk("r5_rs", o_rs_phys, 5);
        chk("r5_rt", o_rt_phys, 6);
        chk("r5_uses_rw", o_uses_rw, 1);
        chk("r5_free_count", o_free_count, 31);
        ren(1, 5, 0, 0, 0, 0);
        chk("r5_read_new", o_rs_phys, 32);
        tick();
        chk("idle_valid_drop", o_valid, 0);

        // Exhaust the free list from a clean reset.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            rw = (k == 0) ? 5'd7 : 5'(8 + (k % 20));
            ren(0, 0, 0, 0, 1, rw);
            chk("alloc_tag", o_rw_phys, 32'(32 + k));
        end
        chk("exhaust_free_count", o_free_count, 0);
        set_in(0, 0, 0, 0, 1, 9);
        #1;
        chk("empty_not_ready", o_ready, 0);
        tick();
        chk("empty_still_not_ready", o_ready, 0);
        chk("empty_valid_drop", o_valid, 0);
        set_commit(7, 32, 7);
        #1;
        chk("no_free_bypass", o_ready, 0);
        tick();
        clear_commit();
        #1;
        chk("recycled_ready", o_ready, 1);
        chk("recycled_free_count", o_free_count, 1);
        tick();
        clear_in();
        chk("recycled_tag", o_rw_phys, 7);
        chk("recycled_old", o_old_rw_phys, 53);
        chk("recycled_free_zero", o_free_count, 0);

        // rw = 0 never allocates, rs = 0 reads phys 0, even with an empty list.
        ren(1, 0, 0, 0, 1, 0);
        chk("r0_valid", o_valid, 1);
        chk("r0_uses_rw", o_uses_rw, 0);
        chk("r0_rw_phys", o_rw_phys, 0);
        chk("r0_rs_phys", o_rs_phys, 0);
        chk("r0_free_count", o_free_count, 0);

        // Flush after committing only r1.
        do_reset();
        ren(0, 0, 0, 0, 1, 1);
        chk("fl_r1_tag", o_rw_phys, 32);
        ren(0, 0, 0, 0, 1, 2);
        chk("fl_r2_tag", o_rw_phys, 33);
        set_commit(1, 32, 1);
        tick();
        clear_commit();
        set_in(0, 0, 0, 0, 1, 5);
        flush = 1'b1;
        #1;
        chk("flush_not_ready", o_ready, 0);
        tick();
        flush = 1'b0;
        clear_in();
        chk("flush_valid", o_valid, 0);
        chk("flush_free_count", o_free_count, 32);
        ren(1, 1, 1, 2, 1, 3);
        chk("post_flush_r1", o_rs_phys, 32);
        chk("post_flush_r2", o_rt_phys, 2);
        chk("post_flush_alloc", o_rw_phys, 1);
        chk("post_flush_old", o_old_rw_phys, 3);
        chk("post_flush_count", o_free_count, 31);

        // Flush with same-cycle commit of r2 -> 33.
        set_commit(2, 33, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_commit();
        chk("flush_commit_count", o_free_count, 32);
        ren(1, 2, 1, 3, 1, 4);
        chk("flush_commit_r2", o_rs_phys, 33);
        chk("flush_commit_r3", o_rt_phys, 3);
        chk("flush_commit_alloc", o_rw_phys, 1);
        chk("flush_commit_old", o_old_rw_phys, 4);

        // Downstream stall: outputs hold for three cycles.
        i_ready = 1'b0;
        set_in(1, 5, 0, 0, 0, 0);
        #1;
        chk("stall_not_ready", o_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_valid", o_valid, 1);
            chk("stall_rs", o_rs_phys, 33);
            chk("stall_rw", o_rw_phys, 1);
            chk("stall_old", o_old_rw_phys, 4);
        end

        // Asynchronous reset mid-stall.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_rs", o_rs_phys, 0);
        chk("arst_rw", o_rw_phys, 0);
        chk("arst_uses_rs", o_uses_rs, 0);
        chk("arst_free_count", o_free_count, 32);
        clear_in();
        i_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("after_reset_ready", o_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_rename_map.md
Name: reg_rename_map

Overview:
- Rename stage placed between decode and the 64-entry physical register file.
- Maps 5-bit architectural rs/rt/rw to 6-bit physical tags and allocates a fresh physical destination from a free-list bitmap.
- Recycles previous mappings at commit.
- Holds a retirement map, so a flush restores precise state in one cycle.

Parameters:
ARCH_REGS, 32, architectural registers (5-bit index)
PHYS_REGS, 64, physical registers (6-bit tag); must match register file depth

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_valid  in  1  decoded instruction valid
o_ready  out  1  rename stage can accept this cycle
i_uses_rs / i_uses_rt / i_uses_rw  in  1 each  operand/dest used
i_rs_addr / i_rt_addr / i_rw_addr  in  5 each  architectural indices
o_valid  out  1  renamed instruction valid
i_ready  in  1  downstream (register file read) accepts
o_uses_rs / o_uses_rt / o_uses_rw  out  1 each  registered copies of uses flags
o_rs_phys / o_rt_phys / o_rw_phys  out  6 each  physical tags
o_old_rw_phys  out  6  prior mapping of rw, freed at commit
commit_valid  in  1  an instruction retires
commit_uses_rw  in  1  retiring instruction wrote a register
commit_rw_addr  in  5  its architectural dest
commit_rw_phys  in  6  its physical dest
commit_old_phys  in  6  mapping to release
flush  in  1  squash all uncommitted instructions
o_free_count  out  7  number of free physical registers

Behaviour:
- Reset:
  - spec_map[i] = i and ret_map[i] = i.
  - free bits 32..63 = 1, bits 0..31 = 0.
  - o_valid = 0; all o_* tags and flags = 0; o_free_count = 32; o_ready = 1.
- Allocation request: need_alloc = i_uses_rw && i_rw_addr != 0.
- Ready: o_ready = !flush && (!o_valid || i_ready) && (!need_alloc || free != 0).
- Accept when i_valid && o_ready. Output register loads on the next clk edge (latency 1); o_valid = 1.
- Accepted instruction, next-cycle outputs:
  - o_rs_phys = uses_rs ? spec_map[rs] : 0; same rule for rt.
  - Sources read the map before this instruction's own dest update, so "add r1,r1,r2" gets the old r1 tag.
  - If need_alloc: o_rw_phys = lowest-indexed set free bit; o_old_rw_phys = spec_map[rw]; spec_map[rw] <= new tag; free bit cleared.
  - Else: o_uses_rw = 0, o_rw_phys = 0, o_old_rw_phys = 0.
- Architectural r0: never renamed, always reads phys 0. Phys 0 is never set in the free bitmap.
- Output holds stable while o_valid && !i_ready.
- If nothing is accepted and i_ready = 1, o_valid drops to 0.
- Commit (commit_valid && commit_uses_rw && commit_rw_addr != 0):
  - ret_map[commit_rw_addr] <= commit_rw_phys.
  - free[commit_old_phys] <= 1 unless it is 0.
  - A freed tag becomes allocatable the next cycle; no same-cycle bypass, even when the bitmap is empty.
- Flush:
  - Highest priority; same-cycle rename is dropped; o_valid <= 0.
  - Any same-cycle commit is applied first.
  - spec_map <= updated ret_map.
  - free <= 1 for every tag not referenced by updated ret_map, excluding 0.
- o_free_count: registered popcount of the free bitmap.
  - Invariant: free_count + live tags = 64, counting phys 0 as live.
- Same-cycle alloc and commit-free of different tags are both applied. They cannot collide on one tag.
- Assert-only conditions:
  - commit freeing a tag that is already free;
  - commit_old_phys == commit_rw_phys.
- Reset mid-operation restores the reset state immediately (asynchronous).

Test Plan:
- Reset then idle → o_valid=0, o_free_count=32, o_ready=1. Rename rs=3, rt=4 with no rw → o_rs_phys=3, o_rt_phys=4, o_uses_rw=0.
- Rename "r5 ← r5,r6" → o_rw_phys=32, o_old_rw_phys=5, o_rs_phys=5. Next instruction reads r5 → o_rs_phys=32; free_count=31.
- 32 back-to-back rw allocations → tags 32..63 in order, free_count=0. 33rd rw instruction → o_ready=0 and held. Commit with old_phys=7 → o_ready=1 the following cycle and allocation returns 7.
- rw=0 with uses_rw=1 → no allocation, o_uses_rw=0, free_count unchanged. rs=0 → o_rs_phys=0.
- Rename r1→32 and r2→33; commit only r1 (old 1); flush → spec r1=32, r2=2. free_count=32 with tag 33 free and tag 1 free. Next rw allocates 1.
- Flush with commit of r2→33 in the same cycle → r2 maps 33 after flush. Hold i_ready=0 with o_valid=1 → outputs stable across 3 cycles. Assert rst mid-stall → outputs zero immediately.
